// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART types and constants for the transmit and receive halves
package usart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Frame phases; the receiver's START_BIT/DATA_BIT/STOP_BIT map onto START/DATA/STOP
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } usart_state_e;

endpackage

// File: rtl/usart_tx.sv
// rtl/usart_tx.sv - USART transmitter, LSB-first 8N1/8N2 frames; optional even parity via USART_TX_PARITY_EN
module usart_tx
    import usart_pkg::*;
#(
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 bit_clock_x16,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 send,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx_pin
);

    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int ST_W     = $clog2(2 * OVERSAMPLE);
    localparam int STOP_LEN = STOP_BITS * OVERSAMPLE;

    localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [ST_W-1:0] STOP_LAST = ST_W'(STOP_LEN - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    usart_state_e         state, state_next;
    logic [OS_W-1:0]      os_cnt, os_next;
    logic [2:0]           bit_cnt, bit_next;
    logic [ST_W-1:0]      stop_cnt, stop_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] hold, hold_next;
    logic                 hold_full, hold_full_next;
    logic                 line_next;
    logic                 done_next;
    logic                 load;
`ifdef USART_TX_PARITY_EN
    logic                 parity, parity_next;
`endif

    assign busy = (state != IDLE) || hold_full;

    // Next-state, datapath updates and the value tx_pin takes on the next edge
    always_comb begin
        state_next     = state;
        os_next        = os_cnt;
        bit_next       = bit_cnt;
        stop_next      = stop_cnt;
        shift_next     = shift;
        hold_next      = hold;
        hold_full_next = hold_full;
        line_next      = 1'b1;
        done_next      = 1'b0;
        load           = 1'b0;
`ifdef USART_TX_PARITY_EN
        parity_next    = parity;
`endif

        if (send && ready) begin
            hold_next      = data_in;
            hold_full_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            START: begin
                line_next = 1'b0;
                os_next   = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) state_next = DATA;
            end
            DATA: begin
                line_next = shift[0];
                os_next   = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) begin
                    shift_next = {1'b0, shift[DATA_BITS-1:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef USART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            PARITY: begin
                line_next = parity;
                os_next   = os_cnt + 1'b1;
                if (os_cnt == OS_LAST) state_next = STOP;
            end
`endif
            STOP: begin
                stop_next = stop_cnt + 1'b1;
                if (stop_cnt == STOP_LAST) begin
                    done_next = 1'b1;
                    stop_next = '0;
                    // A waiting byte starts its start bit right after this stop bit
                    if (hold_full) load = 1'b1;
                    else           state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Holding register moves into the shift register; ready stays low this cycle
        if (load) begin
            shift_next     = hold;
            hold_full_next = 1'b0;
            state_next     = START;
            os_next        = '0;
            bit_next       = '0;
`ifdef USART_TX_PARITY_EN
            parity_next    = ^hold;
`endif
        end
    end

    // State, counters, holding register and registered line/handshake outputs
    always_ff @(posedge bit_clock_x16) begin
        if (reset) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            ready     <= 1'b1;
            tx_pin    <= 1'b1;
            tx_done   <= 1'b0;
`ifdef USART_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            os_cnt    <= os_next;
            bit_cnt   <= bit_next;
            stop_cnt  <= stop_next;
            shift     <= shift_next;
            hold      <= hold_next;
            hold_full <= hold_full_next;
            ready     <= !hold_full_next;
            tx_pin    <= line_next;
            tx_done   <= done_next;
`ifdef USART_TX_PARITY_EN
            parity    <= parity_next;
`endif
        end
    end

endmodule

// File: tb/tb_usart_tx.sv
// tb/tb_usart_tx.sv - self-checking bench for usart_tx against a frame-level reference model
module tb_usart_tx;

    localparam int OS = 16;
`ifdef USART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00, data_in2 = 8'h00;
    logic       send = 1'b0, send2 = 1'b0;
    logic       ready, busy, tx_done, tx_pin;
    logic       ready2, busy2, tx_done2, tx_pin2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usart_tx dut (
        .bit_clock_x16(clk), .reset(reset), .data_in(data_in), .send(send),
        .ready(ready), .busy(busy), .tx_done(tx_done), .tx_pin(tx_pin)
    );

    usart_tx #(.STOP_BITS(2)) dut2 (
        .bit_clock_x16(clk), .reset(reset), .data_in(data_in2), .send(send2),
        .ready(ready2), .busy(busy2), .tx_done(tx_done2), .tx_pin(tx_pin2)
    );

    function automatic int frame_len(input int sb);
        return (10 + sb - 1 + PB) * OS;
    endfunction

    // Expected line level k clocks into a frame, from the frame layout itself
    function automatic logic model_bit(input logic [7:0] b, input int sb, input int k);
        int slot;
        slot = k / OS;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PB == 1 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge
    task automatic send_byte(input int which, input logic [7:0] b);
        int n;
        n = 0;
        while (!(which == 1 ? ready2 : ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("send_wait_timeout", {191'b0, n < 400}, 192'd1);
        if (which == 1) begin data_in2 = b; send2 = 1'b1; end
        else            begin data_in  = b; send  = 1'b1; end
        @(negedge clk);
        send = 1'b0; send2 = 1'b0;
        data_in = 8'($urandom); data_in2 = 8'($urandom);
    endtask

    // Samples ncyc clocks starting at the frame's first start-bit clock
    task automatic run_frame(input int which, input logic [7:0] b, input int ncyc, input string tag);
        logic [191:0] obs, exp, dobs, dexp;
        int sb, len;
        sb = (which == 1) ? 2 : 1;
        len = frame_len(sb);
        obs = '0; exp = '0; dobs = '0; dexp = '0;
        for (int k = 0; k < ncyc; k++) begin
            obs[k]  = (which == 1) ? tx_pin2 : tx_pin;
            dobs[k] = (which == 1) ? tx_done2 : tx_done;
            exp[k]  = model_bit(b, sb, k);
            dexp[k] = (k == len - 1);
            @(negedge clk);
        end
        check({tag, "_line"}, obs, exp);
        check({tag, "_done"}, dobs, dexp);
    endtask

    // Line must stay high with no tx_done for n clocks
    task automatic idle_check(input int which, input int n, input string tag);
        int lows, dones;
        lows = 0; dones = 0;
        for (int k = 0; k < n; k++) begin
            if (((which == 1) ? tx_pin2 : tx_pin) !== 1'b1) lows++;
            if (((which == 1) ? tx_done2 : tx_done) !== 1'b0) dones++;
            @(negedge clk);
        end
        check({tag, "_idle_low"}, 192'(lows), 192'd0);
        check({tag, "_idle_done"}, 192'(dones), 192'd0);
        check({tag, "_idle_busy"}, {191'b0, (which == 1) ? busy2 : busy}, 192'd0);
    endtask

    logic [7:0] rq [5];

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_pin", {191'b0, tx_pin}, 192'd1);
        check("rst_ready", {191'b0, ready}, 192'd1);
        check("rst_busy", {191'b0, busy}, 192'd0);
        check("rst_tx_done", {191'b0, tx_done}, 192'd0);

        // single frame and acceptance latency
        send_byte(0, 8'hA5);
        check("lat_busy", {191'b0, busy}, 192'd1);
        @(negedge clk);
        check("lat_pre_start", {191'b0, tx_pin}, 192'd1);
        @(negedge clk);
        run_frame(0, 8'hA5, frame_len(1), "a5");
        idle_check(0, 40, "a5");

        // back-to-back frames with no idle gap
        send_byte(0, 8'h55);
        repeat (2) @(negedge clk);
        fork
            begin
                run_frame(0, 8'h55, frame_len(1), "b2b_55");
                run_frame(0, 8'h0F, frame_len(1), "b2b_0f");
            end
            send_byte(0, 8'h0F);
        join
        idle_check(0, 40, "b2b");

        // send while ready=0 is dropped
        send_byte(0, 8'h11);
        repeat (2) @(negedge clk);
        fork
            begin
                run_frame(0, 8'h11, frame_len(1), "drop_11");
                run_frame(0, 8'h22, frame_len(1), "drop_22");
            end
            begin
                send_byte(0, 8'h22);
                check("drop_ready_low", {191'b0, ready}, 192'd0);
                data_in = 8'h33; send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        join
        idle_check(0, 200, "drop");

        // reset during data bit 3 with a byte held
        send_byte(0, 8'hFF);
        repeat (2) @(negedge clk);
        fork
            run_frame(0, 8'hFF, 70, "abort_ff");
            send_byte(0, 8'hAA);
        join
        check("abort_held", {191'b0, ready}, 192'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_tx_pin", {191'b0, tx_pin}, 192'd1);
        check("abort_ready", {191'b0, ready}, 192'd1);
        check("abort_busy", {191'b0, busy}, 192'd0);
        check("abort_tx_done", {191'b0, tx_done}, 192'd0);
        idle_check(0, 300, "abort");

        // two stop bits
        send_byte(1, 8'h00);
        repeat (2) @(negedge clk);
        run_frame(1, 8'h00, frame_len(2), "sb2_00");
        idle_check(1, 40, "sb2");

        // parity-relevant bytes (plain frames when parity is disabled)
        send_byte(0, 8'h07);
        repeat (2) @(negedge clk);
        run_frame(0, 8'h07, frame_len(1), "par_07");
        send_byte(0, 8'h03);
        repeat (2) @(negedge clk);
        run_frame(0, 8'h03, frame_len(1), "par_03");

        // random back-to-back stream
        foreach (rq[i]) rq[i] = 8'($urandom);
        send_byte(0, rq[0]);
        repeat (2) @(negedge clk);
        fork
            for (int i = 0; i < 5; i++) run_frame(0, rq[i], frame_len(1), $sformatf("rnd%0d", i));
            for (int j = 1; j < 5; j++) send_byte(0, rq[j]);
        join
        idle_check(0, 40, "rnd");

        // random byte on the two-stop-bit instance
        rq[0] = 8'($urandom);
        send_byte(1, rq[0]);
        repeat (2) @(negedge clk);
        run_frame(1, rq[0], frame_len(2), "rnd_sb2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
